sc_et_decoder: RTL
==================

# sc_et_decoder

Stochastic-to-binary decoder that sits directly downstream of the early-terminating SC bitstream generator (`cape_ET`). It counts the ones on each of the generator's `NUM_INPUTS` bitstreams, and tracks the number of beats. When the generator signals termination, it normalises each count by the variable stream length, which is 2^k after early termination. It then presents the recovered `WIDTH`-bit binary values on a valid/ready output port.

## Interface
- `WIDTH`, 4: binary precision of each recovered value; matches the generator's `WIDTH`.
- `NUM_INPUTS`, 2: number of parallel bitstreams; matches the generator's `NUM_INPUTS`.
- Derived `CW` = `NUM_INPUTS*WIDTH+1`: width of the beat counter and each ones counter; maximum stream length is 2^(`NUM_INPUTS*WIDTH`).

Ports:
- `clk`, in, 1: single clock; everything is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: the `Xs` bits are a valid beat this cycle.
- `in_last`, in, 1: generator `done`; with `in_valid`=1 the beat is the final beat; with `in_valid`=0 the stream ends with no extra beat.
- `Xs`, in, `NUM_INPUTS`: one stochastic bit per stream.
- `busy`, out, 1: high in NORM and HOLD; while high, beats are not accepted.
- `out_valid`, out, 1: `Zs` and `out_len_log2` are valid.
- `out_ready`, in, 1: consumer accepts the result.
- `Zs`, out, `NUM_INPUTS*WIDTH`: recovered values; stream i occupies `Zs[i*WIDTH +: WIDTH]`.
- `out_len_log2`, out, `$clog2(CW)`: k = floor(log2(beat count)); 0 when the beat count is 0.
- `len_err`, out, 1: the finished stream length was not a power of two, or was 0.
- `overrun`, out, 1: sticky; set if `in_valid` or `in_last` is seen while `busy`.

## Operation
- Reset (`rst`=1 at an edge), applied from any state: state becomes ACCUM. All counters clear. `out_valid`=0, `Zs`=0, `out_len_log2`=0, `len_err`=0, `overrun`=0, `busy`=0.
- ACCUM:
  - Each cycle with `in_valid`=1: the beat counter increments by 1, and `ones[i]` increments where `Xs[i]`=1.
  - Both counters saturate at 2^(`CW`-1). Any beat arriving at saturation sets the internal `len_err` flag.
  - `in_last`=1 (with or without `in_valid`) moves the state to NORM. The beat on that cycle, if any, is counted first.
- NORM, exactly one cycle:
  - Let L = beat count and k = floor(log2 L).
  - `Zs[i]` = (`ones[i]` << `WIDTH`) >> k, truncated and saturated to 2^`WIDTH`-1.
  - If L=0: `Zs`=0, k=0, `len_err`=1.
  - `len_err`=1 if L is not a power of two.
  - Registers the outputs and moves to HOLD.
- HOLD:
  - `out_valid`=1; `Zs`, `out_len_log2` and `len_err` are stable.
  - On `out_valid && out_ready`: counters clear, `len_err` clears, state returns to ACCUM, and `out_valid`=0 from the next cycle.
- Inputs while `busy`: they are ignored and set `overrun`. `overrun` clears only on reset.
- `in_last` in the same cycle as the HOLD handshake: dropped, and `overrun` is set.

## Timing
- The final beat (or the bare `in_last`) is sampled at edge N. NORM runs in cycle N→N+1. `out_valid` rises after edge N+1, so latency is 2 cycles from the last beat to `out_valid`.
- `busy` rises after edge N.
- `out_ready` is sampled only in HOLD; asserting it earlier has no effect.
- Back-to-back streams: the first beat of the next stream may arrive in the cycle after the handshake edge. Minimum gap between streams is 3 cycles (NORM + HOLD + handshake).
- With no output backpressure, ACCUM accepts one beat every cycle.

## Test plan
- Stream 1: 8 beats with per-stream ones counts `ones`={6,4}, `in_last` on beat 8, `out_ready`=1.
  - Required: `Zs`={4'b1100, 4'b1000}, `out_len_log2`=3, `len_err`=0.
  - `out_valid` is high exactly 2 cycles after the last beat.
- Stream 2: 256 beats with `ones`={208,144}.
  - Required: `Zs`={4'b1101, 4'b1001}, `out_len_log2`=8.
- Stream 3: 16 beats with `ones`={5,0}.
  - Required: `Zs`={4'b0101, 4'b0000}.
  - Then hold `out_ready`=0 for 5 cycles: `out_valid` and `Zs` stay stable, and `busy`=1.
- Length and empty-stream errors:
  - 12 beats with `ones`={12,6}: `len_err`=1, k=3, `Zs`={4'b1111 (saturated), 4'b1100}.
  - Bare `in_last` with no beats: `Zs`=0, `len_err`=1.
- Overrun:
  - `in_valid` asserted during HOLD: `overrun`=1, and the counts of the next stream are unaffected by the dropped beats.
- Mid-stream reset:
  - `rst` after 3 beats: all outputs 0.
  - A following 8-beat stream with `ones`={6,4} then decodes to {4'b1100, 4'b1000}.

Source files
------------

// File: rtl/sc_et_decoder.sv
// Stochastic-to-binary decoder for the early-terminating SC bitstream generator.
// Counts ones per stream, then normalises each count by the 2^k stream length on termination.
module sc_et_decoder #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned NUM_INPUTS = 2,
  localparam int unsigned CW        = NUM_INPUTS * WIDTH + 1,
  localparam int unsigned LW        = $clog2(CW)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [NUM_INPUTS-1:0]       Xs,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_INPUTS*WIDTH-1:0] Zs,
  output logic [LW-1:0]               out_len_log2,
  output logic                        len_err,
  output logic                        overrun
);

  typedef enum logic [1:0] {StAccum, StNorm, StHold} state_e;

  localparam logic [CW-1:0] SatVal = {1'b1, {(CW-1){1'b0}}};

  state_e                        r_state;
  logic [CW-1:0]                 r_beats;
  logic [CW-1:0]                 r_ones [NUM_INPUTS];
  logic                          r_sat_err;
  logic                          r_busy;
  logic                          r_out_valid;
  logic [NUM_INPUTS*WIDTH-1:0]   r_zs;
  logic [LW-1:0]                 r_k;
  logic                          r_len_err;
  logic                          r_overrun;

  logic                          w_beat_ok;
  logic [LW-1:0]                 w_k;
  logic                          w_pow2;
  logic                          w_len_err;
  logic [CW+WIDTH-1:0]           w_prod;
  logic [NUM_INPUTS*WIDTH-1:0]   w_zs;
  logic                          w_in_any;

  assign w_beat_ok = (r_beats != SatVal);
  assign w_in_any  = in_valid | in_last;

  // k = index of the highest set bit of the beat count; 0 for an empty stream.
  always_comb begin
    w_k = '0;
    for (int b = 0; b < CW; b++) begin
      if (r_beats[b]) w_k = LW'(b);
    end
  end

  assign w_pow2    = (r_beats != '0) && ((r_beats & (r_beats - CW'(1))) == '0);
  assign w_len_err = r_sat_err | ~w_pow2;

  // Zs[i] = (ones[i] << WIDTH) >> k, clamped to the all-ones code when it overflows.
  always_comb begin
    w_zs   = '0;
    w_prod = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_prod = {r_ones[i], {WIDTH{1'b0}}} >> w_k;
      if (r_beats == '0) begin
        w_zs[i*WIDTH +: WIDTH] = '0;
      end else if (|w_prod[CW+WIDTH-1:WIDTH]) begin
        w_zs[i*WIDTH +: WIDTH] = '1;
      end else begin
        w_zs[i*WIDTH +: WIDTH] = w_prod[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StAccum;
      r_beats     <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) r_ones[i] <= '0;
      r_sat_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_zs        <= '0;
      r_k         <= '0;
      r_len_err   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      case (r_state)
        StAccum: begin
          if (in_valid) begin
            if (w_beat_ok) begin
              r_beats <= r_beats + CW'(1);
              for (int i = 0; i < NUM_INPUTS; i++) begin
                if (Xs[i]) r_ones[i] <= r_ones[i] + CW'(1);
              end
            end else begin
              r_sat_err <= 1'b1;
            end
          end
          if (in_last) begin
            r_state <= StNorm;
            r_busy  <= 1'b1;
          end
        end
        StNorm: begin
          if (w_in_any) r_overrun <= 1'b1;
          r_zs        <= w_zs;
          r_k         <= (r_beats == '0) ? '0 : w_k;
          r_len_err   <= w_len_err;
          r_out_valid <= 1'b1;
          r_state     <= StHold;
        end
        StHold: begin
          // A beat or in_last coinciding with the handshake is dropped as well.
          if (w_in_any) r_overrun <= 1'b1;
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_len_err   <= 1'b0;
            r_beats     <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) r_ones[i] <= '0;
            r_sat_err   <= 1'b0;
            r_state     <= StAccum;
          end
        end
        default: r_state <= StAccum;
      endcase
    end
  end

  assign busy         = r_busy;
  assign out_valid    = r_out_valid;
  assign Zs           = r_zs;
  assign out_len_log2 = r_k;
  assign len_err      = r_len_err;
  assign overrun      = r_overrun;

endmodule
